// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter shared by the MEM-stage CPU access and a DMA/loader requester.
// Optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [2:0]            cpu_funct3_i,
    input  logic [DATA_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_done_o,
    output logic                  cpu_stall_o,
    input  logic                  dma_valid_i,
    output logic                  dma_ready_o,
    input  logic                  dma_we_i,
    input  logic [DATA_WIDTH-1:0] dma_addr_i,
    input  logic [DATA_WIDTH-1:0] dma_wdata_i,
    output logic [DATA_WIDTH-1:0] dma_rdata_o,
    output logic                  dma_rvalid_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [2:0]            mem_funct3_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_cpu_grants_o,
    output logic [31:0]           perf_dma_grants_o,
    output logic [31:0]           perf_stall_cycles_o
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LATENCY - 2);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [3:0]            starve_q, starve_d;
    logic [3:0]            lat_q, lat_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic grantCpu;
    logic grantDma;

    // DMA wins a contest only once the CPU has starved it STARVE_LIMIT times in a row.
    assign grantDma    = dma_valid_i && (!cpu_req_i || (starve_q == STARVE_MAX));
    assign grantCpu    = cpu_req_i && !grantDma;
    assign dma_ready_o = (state_q == IDLE) && grantDma && !rst;
    assign cpu_stall_o = cpu_req_i && !((state_q == DONE) && (owner_q == OWN_CPU));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_CPU;
            starve_q <= '0;
            lat_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            lat_q    <= lat_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        lat_d        = lat_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_o  = '0;
        cpu_done_o   = 1'b0;
        dma_rdata_o  = '0;
        dma_rvalid_o = 1'b0;
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_funct3_o = '0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;

        case (state_q)
            IDLE: begin
                if (grantDma) begin
                    state_d  = ISSUE;
                    owner_d  = OWN_DMA;
                    we_d     = dma_we_i;
                    funct3_d = 3'b010;
                    addr_d   = dma_addr_i;
                    wdata_d  = dma_wdata_i;
                    starve_d = '0;
                end else if (grantCpu) begin
                    state_d  = ISSUE;
                    owner_d  = OWN_CPU;
                    we_d     = cpu_we_i;
                    funct3_d = cpu_funct3_i;
                    addr_d   = cpu_addr_i;
                    wdata_d  = cpu_wdata_i;
                    if (dma_valid_i && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            ISSUE: begin
                mem_en_o     = 1'b1;
                mem_we_o     = we_q;
                mem_funct3_o = funct3_q;
                mem_addr_o   = addr_q;
                mem_wdata_o  = wdata_q;
                lat_d        = '0;
                state_d      = (we_q || (MEM_LATENCY == 1)) ? DONE : WAIT;
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = DONE;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            DONE: begin
                if (owner_q == OWN_DMA) begin
                    dma_rdata_o  = mem_rdata_i;
                    dma_rvalid_o = 1'b1;
                end else begin
                    cpu_rdata_o  = mem_rdata_i;
                    cpu_done_o   = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perfCpu_q, perfDma_q, perfStall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfCpu_q   <= '0;
            perfDma_q   <= '0;
            perfStall_q <= '0;
        end else begin
            if ((state_q == IDLE) && grantCpu) perfCpu_q <= perfCpu_q + 32'd1;
            if ((state_q == IDLE) && grantDma) perfDma_q <= perfDma_q + 32'd1;
            if (cpu_stall_o) perfStall_q <= perfStall_q + 32'd1;
        end
    end

    assign perf_cpu_grants_o   = perfCpu_q;
    assign perf_dma_grants_o   = perfDma_q;
    assign perf_stall_cycles_o = perfStall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MEM_LATENCY=1/STARVE_LIMIT=2, one at MEM_LATENCY=3.
// Define DMEM_ARB_PERF_EN to also check the performance counters.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req [2];
    logic        dma_valid [2];
    logic        cpu_we, dma_we;
    logic [2:0]  cpu_f3;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

    logic [31:0] cpu_rdata [2], dma_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic        cpu_done [2], cpu_stall [2], dma_ready [2], dma_rvalid [2], mem_en [2], mem_we [2];
    logic [2:0]  mem_f3 [2];

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];
    logic [31:0] pipe0 [3];
    logic [31:0] pipe1 [3];

    int testsRun = 0;
    int failures = 0;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perfCpu [2], perfDma [2], perfStall [2];
    int stallSeen;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(2)) u_lat1 (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req[0]), .cpu_we_i(cpu_we), .cpu_funct3_i(cpu_f3),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata[0]),
        .cpu_done_o(cpu_done[0]), .cpu_stall_o(cpu_stall[0]),
        .dma_valid_i(dma_valid[0]), .dma_ready_o(dma_ready[0]), .dma_we_i(dma_we),
        .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata), .dma_rdata_o(dma_rdata[0]),
        .dma_rvalid_o(dma_rvalid[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_funct3_o(mem_f3[0]),
        .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0])
`ifdef DMEM_ARB_PERF_EN
        , .perf_cpu_grants_o(perfCpu[0]), .perf_dma_grants_o(perfDma[0]),
        .perf_stall_cycles_o(perfStall[0])
`endif
    );

    dmem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_lat3 (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req[1]), .cpu_we_i(cpu_we), .cpu_funct3_i(cpu_f3),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata[1]),
        .cpu_done_o(cpu_done[1]), .cpu_stall_o(cpu_stall[1]),
        .dma_valid_i(dma_valid[1]), .dma_ready_o(dma_ready[1]), .dma_we_i(dma_we),
        .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata), .dma_rdata_o(dma_rdata[1]),
        .dma_rvalid_o(dma_rvalid[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_funct3_o(mem_f3[1]),
        .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1])
`ifdef DMEM_ARB_PERF_EN
        , .perf_cpu_grants_o(perfCpu[1]), .perf_dma_grants_o(perfDma[1]),
        .perf_stall_cycles_o(perfStall[1])
`endif
    );

    // Memory model: stores merge by size, loads extract and extend by funct3.
    function automatic logic [31:0] storeMerge(logic [31:0] old, logic [31:0] a,
                                               logic [2:0] f3, logic [31:0] d);
        logic [31:0] r;
        r = old;
        case (f3[1:0])
            2'b00:   r[{a[1:0], 3'b000} +: 8] = d[7:0];
            2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] loadExtract(logic [31:0] w, logic [31:0] a, logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a[1:0], 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en[0]) begin
            if (mem_we[0]) mem0[mem_addr[0][5:2]] <= storeMerge(mem0[mem_addr[0][5:2]], mem_addr[0], mem_f3[0], mem_wdata[0]);
            else           pipe0[0] <= loadExtract(mem0[mem_addr[0][5:2]], mem_addr[0], mem_f3[0]);
        end
        pipe0[1] <= pipe0[0];
        pipe0[2] <= pipe0[1];
    end

    always @(posedge clk) begin
        if (mem_en[1]) begin
            if (mem_we[1]) mem1[mem_addr[1][5:2]] <= storeMerge(mem1[mem_addr[1][5:2]], mem_addr[1], mem_f3[1], mem_wdata[1]);
            else           pipe1[0] <= loadExtract(mem1[mem_addr[1][5:2]], mem_addr[1], mem_f3[1]);
        end
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end

    assign mem_rdata[0] = pipe0[0];
    assign mem_rdata[1] = pipe1[2];

`ifdef DMEM_ARB_PERF_EN
    always @(negedge clk) begin
        if (rst)               stallSeen <= 0;
        else if (cpu_stall[0]) stallSeen <= stallSeen + 1;
    end
`endif

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One CPU access; reports the cycle of cpu_done (1 = request cycle) and what was issued.
    task automatic applyStimulus(input int inst, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output int doneCycle,
                                 output int stallCycles, output int enCycles, output int leaks,
                                 output logic issueWe, output logic [2:0] issueF3,
                                 output logic [31:0] issueAddr, output logic [31:0] issueWdata);
        rdata = '0; doneCycle = 0; stallCycles = 0; enCycles = 0; leaks = 0;
        issueWe = 1'b0; issueF3 = '0; issueAddr = '0; issueWdata = '0;
        @(posedge clk); #1;
        cpu_we = we; cpu_f3 = f3; cpu_addr = addr; cpu_wdata = wdata;
        cpu_req[inst] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (cpu_stall[inst]) stallCycles++;
            if (mem_en[inst]) begin
                enCycles++;
                issueWe = mem_we[inst]; issueF3 = mem_f3[inst];
                issueAddr = mem_addr[inst]; issueWdata = mem_wdata[inst];
            end else if (mem_addr[inst] != 0 || mem_wdata[inst] != 0 || mem_we[inst]) begin
                leaks++;
            end
            if (cpu_done[inst]) begin
                doneCycle = c;
                rdata = cpu_rdata[inst];
                break;
            end else if (cpu_rdata[inst] != 0) begin
                leaks++;
            end
        end
        @(posedge clk); #1;
        cpu_req[inst] = 1'b0;
    endtask

    task automatic applyDmaStimulus(input int inst, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, output logic [31:0] rdata,
                                    output int readyCycle, output int rvalidCycle,
                                    output logic [2:0] issueF3);
        rdata = '0; readyCycle = 0; rvalidCycle = 0; issueF3 = '0;
        @(posedge clk); #1;
        dma_we = we; dma_addr = addr; dma_wdata = wdata;
        dma_valid[inst] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_en[inst]) issueF3 = mem_f3[inst];
            if (dma_rvalid[inst]) begin
                rvalidCycle = c;
                rdata = dma_rdata[inst];
                break;
            end
            if (dma_ready[inst] && readyCycle == 0) begin
                readyCycle = c;
                @(posedge clk); #1;
                dma_valid[inst] = 1'b0;
            end
        end
        dma_valid[inst] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, iAddr, iWdata;
        logic        iWe;
        logic [2:0]  iF3;
        int          doneC, stallC, enC, leakC, readyC, rvalidC;
        int          grants, doneDuringRst;
        logic [5:0]  grantMask, readyMask;
        logic [31:0] starveRd;

        rst = 1'b1;
        cpu_req[0] = 1'b1; dma_valid[0] = 1'b1;
        cpu_req[1] = 1'b0; dma_valid[1] = 1'b0;
        cpu_we = 1'b0; cpu_f3 = 3'b010; cpu_addr = 32'h10; cpu_wdata = '0;
        dma_we = 1'b0; dma_addr = 32'h30; dma_wdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_stall_follows_req", {31'b0, cpu_stall[0]}, 32'd1);
        checkOutput("rst_stall_idle",        {31'b0, cpu_stall[1]}, 32'd0);
        checkOutput("rst_dma_ready",         {31'b0, dma_ready[0]}, 32'd0);
        checkOutput("rst_mem_en",            {31'b0, mem_en[0]},    32'd0);
        checkOutput("rst_cpu_done",          {31'b0, cpu_done[0]},  32'd0);
        checkOutput("rst_mem_addr",          mem_addr[0],           32'd0);
        cpu_req[0] = 1'b0; dma_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Latency-1 instance: preload, lone load, DMA write.
        applyStimulus(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, doneC, stallC, enC, leakC, iWe, iF3, iAddr, iWdata);
        checkOutput("l1_store_done_cycle", doneC, 3);
        applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, doneC, stallC, enC, leakC, iWe, iF3, iAddr, iWdata);
        checkOutput("l1_load_done_cycle", doneC, 3);
        checkOutput("l1_load_rdata",      rd, 32'hDEADBEEF);
        checkOutput("l1_load_en_cycles",  enC, 1);
        checkOutput("l1_load_stall",      stallC, 2);
        checkOutput("l1_load_issue_addr", iAddr, 32'h10);
        checkOutput("l1_load_leaks",      leakC, 0);
        applyDmaStimulus(0, 1'b1, 32'h30, 32'hCAFEF00D, rd, readyC, rvalidC, iF3);
        checkOutput("l1_dma_ready_cycle",  readyC, 1);
        checkOutput("l1_dma_rvalid_cycle", rvalidC, 3);
        checkOutput("l1_dma_funct3",       {29'b0, iF3}, 32'd2);

        // Starvation: CPU and DMA both held; expect C C D C C D.
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_f3 = 3'b010; cpu_addr = 32'h10;
        dma_we = 1'b0; dma_addr = 32'h30;
        cpu_req[0] = 1'b1; dma_valid[0] = 1'b1;
        grants = 0; grantMask = '0; readyMask = '0; starveRd = '0;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            @(negedge clk);
            if (dma_ready[0]) readyMask[grants] = 1'b1;
            if (dma_rvalid[0]) starveRd = dma_rdata[0];
            if (mem_en[0]) begin
                grantMask[grants] = (mem_addr[0] == 32'h30);
                grants++;
            end
        end
        @(posedge clk); #1;
        cpu_req[0] = 1'b0; dma_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        checkOutput("starve_grant_count", grants, 6);
        checkOutput("starve_grant_order", {26'b0, grantMask}, 32'h24);
        checkOutput("starve_ready_order", {26'b0, readyMask}, 32'h24);
        checkOutput("starve_dma_rdata",   starveRd, 32'hCAFEF00D);

`ifdef DMEM_ARB_PERF_EN
        @(posedge clk); #1;
        checkOutput("perf_cpu_grants",   perfCpu[0], 32'd6);
        checkOutput("perf_dma_grants",   perfDma[0], 32'd3);
        checkOutput("perf_stall_cycles", perfStall[0], 32'(stallSeen));
`endif

        // Latency-3 instance: word preload, byte store, byte and word reads, DMA read.
        applyStimulus(1, 1'b1, 3'b010, 32'h20, 32'hAABBCCDD, rd, doneC, stallC, enC, leakC, iWe, iF3, iAddr, iWdata);
        checkOutput("l3_store_word_done", doneC, 3);
        applyStimulus(1, 1'b1, 3'b000, 32'h20, 32'h12345678, rd, doneC, stallC, enC, leakC, iWe, iF3, iAddr, iWdata);
        checkOutput("l3_sb_done_cycle",  doneC, 3);
        checkOutput("l3_sb_mem_we",      {31'b0, iWe}, 32'd1);
        checkOutput("l3_sb_funct3",      {29'b0, iF3}, 32'd0);
        checkOutput("l3_sb_addr",        iAddr, 32'h20);
        checkOutput("l3_sb_wdata",       iWdata, 32'h12345678);
        checkOutput("l3_sb_stall",       stallC, 2);
        applyStimulus(1, 1'b0, 3'b000, 32'h20, 32'h0, rd, doneC, stallC, enC, leakC, iWe, iF3, iAddr, iWdata);
        checkOutput("l3_lb_rdata",       rd, 32'h78);
        checkOutput("l3_lb_done_cycle",  doneC, 5);
        checkOutput("l3_lb_stall",       stallC, 4);
        checkOutput("l3_lb_en_cycles",   enC, 1);
        checkOutput("l3_lb_leaks",       leakC, 0);
        applyStimulus(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, doneC, stallC, enC, leakC, iWe, iF3, iAddr, iWdata);
        checkOutput("l3_lw_rdata",       rd, 32'hAABBCC78);
        applyDmaStimulus(1, 1'b0, 32'h20, 32'h0, rd, readyC, rvalidC, iF3);
        checkOutput("l3_dma_rvalid_cycle", rvalidC, 5);
        checkOutput("l3_dma_rdata",        rd, 32'hAABBCC78);

        // Reset during WAIT of a CPU read on the latency-3 instance.
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_f3 = 3'b010; cpu_addr = 32'h20;
        cpu_req[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_issue_en", {31'b0, mem_en[1]}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_mem_en",   {31'b0, mem_en[1]},   32'd0);
        checkOutput("midrst_cpu_done", {31'b0, cpu_done[1]}, 32'd0);
        doneDuringRst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cpu_done[1] || mem_en[1]) doneDuringRst++;
        end
        cpu_req[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cpu_done[1]) doneDuringRst++;
        end
        checkOutput("midrst_no_done", doneDuringRst, 0);
        applyStimulus(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, doneC, stallC, enC, leakC, iWe, iF3, iAddr, iWdata);
        checkOutput("postrst_done_cycle", doneC, 5);
        checkOutput("postrst_rdata",      rd, 32'hAABBCC78);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
